rv32imf_apu_arbiter: RTL and testbench

Shares one APU (floating-point / multicycle unit) between NUM_REQ requesters, e.g. two cores or the core FPU path plus a debug/test master. Performs round-robin request arbitration with a grant lock, tracks outstanding operations in an in-order ID FIFO, and steers each APU response back to the requester that issued it. Sits between the requesters' APU dispatch interfaces and the single APU instance.

---
 rtl/rv32imf_pkg.sv | 19 +
 rtl/rv32imf_apu_id_fifo.sv | 64 ++++++
 rtl/rv32imf_apu_arbiter.sv | 128 ++++++++++++
 tb/tb_rv32imf_apu_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32imf_pkg.sv
// Shared constants and types for the rv32imf APU sharing logic.
package rv32imf_pkg;

    localparam int unsigned APU_PAYLOAD_W       = 128;
    localparam int unsigned APU_RESULT_W        = 37;
    localparam int unsigned APU_NUM_REQ         = 2;
    localparam int unsigned APU_MAX_OUTSTANDING = 2;

    typedef enum logic [0:0] {
        StOpen,
        StLocked
    } lock_state_e;

    // Index width that stays legal (>= 1 bit) for degenerate sizes.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv32imf_apu_id_fifo.sv
// In-order FIFO of requester IDs; the caller guarantees no push when full and no pop when empty.
module rv32imf_apu_id_fifo
    import rv32imf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ID_W  = 1,
    localparam int unsigned PtrW = id_width(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [ID_W-1:0] id_i,
    input  logic            pop_i,
    output logic [ID_W-1:0] head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [ID_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= id_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/rv32imf_apu_arbiter.sv
// Round-robin arbiter with grant lock sharing one APU between requesters, with in-order response
// steering back to the issuing requester.
module rv32imf_apu_arbiter
    import rv32imf_pkg::*;
#(
    parameter int unsigned NUM_REQ         = APU_NUM_REQ,
    parameter int unsigned MAX_OUTSTANDING = APU_MAX_OUTSTANDING,
    parameter int unsigned PAYLOAD_W       = APU_PAYLOAD_W,
    parameter int unsigned RESULT_W        = APU_RESULT_W,
    localparam int unsigned IdW  = id_width(NUM_REQ),
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] payload_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [RESULT_W-1:0]               result_o,
    output logic                              apu_req_o,
    output logic [PAYLOAD_W-1:0]              apu_payload_o,
    input  logic                              apu_gnt_i,
    input  logic                              apu_rvalid_i,
    input  logic [RESULT_W-1:0]               apu_result_i,
    output logic                              busy_o,
    output logic [CntW-1:0]                   outstanding_o,
    output logic                              err_o
);

    lock_state_e    lock_state_q, lock_state_d;
    logic [IdW-1:0] lock_id_q, lock_id_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic           err_q, err_d;

    logic [IdW-1:0]  rr_winner;
    logic [IdW-1:0]  winner;
    logic [IdW-1:0]  head_id;
    logic            full;
    logic            empty;
    logic            handshake;
    logic            pop;
    logic [CntW-1:0] count;

    // First asserted request at or above rr_ptr, wrapping around.
    always_comb begin
        logic           found;
        int unsigned    idx;
        logic [IdW-1:0] cand;
        rr_winner = rr_ptr_q;
        found     = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IdW'(idx);
            if (!found && req_i[cand]) begin
                rr_winner = cand;
                found     = 1'b1;
            end
        end
    end

    assign winner        = (lock_state_q == StLocked) ? lock_id_q : rr_winner;
    assign apu_req_o     = (|req_i) & ~full;
    assign apu_payload_o = payload_i[winner];
    assign handshake     = apu_req_o & apu_gnt_i & req_i[winner];
    assign pop           = apu_rvalid_i & ~empty;
    assign result_o      = apu_result_i;

    always_comb begin
        gnt_o           = '0;
        gnt_o[winner]   = apu_gnt_i & ~full;
        rvalid_o        = '0;
        rvalid_o[head_id] = pop;
    end

    always_comb begin
        lock_state_d = lock_state_q;
        lock_id_d    = lock_id_q;
        rr_ptr_d     = rr_ptr_q;
        err_d        = err_q | (apu_rvalid_i & empty);
        if (handshake) begin
            lock_state_d = StOpen;
            rr_ptr_d     = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + IdW'(1);
        end else if (apu_req_o && !apu_gnt_i) begin
            // Hold the presented payload stable until the APU takes it.
            lock_state_d = StLocked;
            lock_id_d    = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_state_q <= StOpen;
            lock_id_q    <= '0;
            rr_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_id_q    <= lock_id_d;
            rr_ptr_q     <= rr_ptr_d;
            err_q        <= err_d;
        end
    end

    rv32imf_apu_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .id_i    (winner),
        .pop_i   (pop),
        .head_o  (head_id),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign busy_o        = (count != '0);
    assign outstanding_o = count;
    assign err_o         = err_q;

endmodule

// File: tb/tb_rv32imf_apu_arbiter.sv
// Vector-table bench for rv32imf_apu_arbiter with an ID scoreboard and a mid-operation reset case.
module tb_rv32imf_apu_arbiter;

    localparam int NREQ = 2;
    localparam int PW   = 128;
    localparam int RW   = 37;
    localparam int NVEC = 27;

    logic                      clk;
    logic                      rst_ni;
    logic [NREQ-1:0]           req_i;
    logic [NREQ-1:0][PW-1:0]   payload_i;
    logic [NREQ-1:0]           gnt_o;
    logic [NREQ-1:0]           rvalid_o;
    logic [RW-1:0]             result_o;
    logic                      apu_req_o;
    logic [PW-1:0]             apu_payload_o;
    logic                      apu_gnt_i;
    logic                      apu_rvalid_i;
    logic [RW-1:0]             apu_result_i;
    logic                      busy_o;
    logic [1:0]                outstanding_o;
    logic                      err_o;

    rv32imf_apu_arbiter #(
        .NUM_REQ         (NREQ),
        .MAX_OUTSTANDING (2),
        .PAYLOAD_W       (PW),
        .RESULT_W        (RW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .payload_i     (payload_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .result_o      (result_o),
        .apu_req_o     (apu_req_o),
        .apu_payload_o (apu_payload_o),
        .apu_gnt_i     (apu_gnt_i),
        .apu_rvalid_i  (apu_rvalid_i),
        .apu_result_i  (apu_result_i),
        .busy_o        (busy_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [36:0] res;
        logic [1:0]  egnt;
        logic [1:0]  erv;
        logic        eareq;
        logic [1:0]  eout;
        logic        eerr;
        int          psel;
    } vec_t;

    vec_t vecs [NVEC];
    int   errors = 0;
    int   checks = 0;
    int   exp_q [$];
    logic [PW-1:0] pay [NREQ];

    function automatic vec_t mk(input logic [1:0] req, input logic gnt, input logic rv,
                                input logic [36:0] res, input logic [1:0] egnt,
                                input logic [1:0] erv, input logic eareq,
                                input logic [1:0] eout, input logic eerr, input int psel);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.res = res; v.egnt = egnt;
        v.erv = erv; v.eareq = eareq; v.eout = eout; v.eerr = eerr; v.psel = psel;
        return v;
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check();
        int id;
        if (rvalid_o != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got rvalid %0b, expected no response", rvalid_o);
            end else begin
                id = exp_q.pop_front();
                check("sb_id", PW'(rvalid_o), PW'(2'b01 << id));
            end
        end
    endtask

    initial begin
        pay[0] = {4{32'h1111_A0A0}};
        pay[1] = {4{32'h2222_B1B1}};
        payload_i[0] = pay[0];
        payload_i[1] = pay[1];

        // req gnt rv res | egnt erv eareq eout eerr psel
        vecs[0]  = mk(2'b11, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0);
        vecs[1]  = mk(2'b11, 1, 1, 0, 2'b10, 2'b01, 1, 1, 0, 1);
        vecs[2]  = mk(2'b11, 1, 1, 0, 2'b01, 2'b10, 1, 1, 0, 0);
        vecs[3]  = mk(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 1, 0, 0);
        vecs[4]  = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[5]  = mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[6]  = mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[7]  = mk(2'b11, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[8]  = mk(2'b11, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0);
        vecs[9]  = mk(2'b10, 1, 0, 0, 2'b10, 2'b00, 1, 1, 0, 1);
        vecs[10] = mk(2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 2, 0, 0);
        vecs[11] = mk(2'b01, 1, 1, 0, 2'b00, 2'b01, 0, 2, 0, 0);
        vecs[12] = mk(2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0, 0);
        vecs[13] = mk(2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 2, 0, 0);
        vecs[14] = mk(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 1, 0, 0);
        vecs[15] = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[16] = mk(2'b10, 1, 0, 0, 2'b10, 2'b00, 1, 0, 0, 1);
        vecs[17] = mk(2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0, 0);
        vecs[18] = mk(2'b00, 0, 1, 37'hA, 2'b00, 2'b10, 0, 2, 0, 0);
        vecs[19] = mk(2'b00, 0, 1, 37'hB, 2'b00, 2'b01, 0, 1, 0, 0);
        vecs[20] = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[21] = mk(2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[22] = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        vecs[23] = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
        vecs[24] = mk(2'b11, 1, 0, 0, 2'b10, 2'b00, 1, 0, 1, 1);
        vecs[25] = mk(2'b11, 1, 0, 0, 2'b01, 2'b00, 1, 1, 1, 0);
        vecs[26] = mk(2'b11, 0, 0, 0, 2'b00, 2'b00, 0, 2, 1, 0);

        rst_ni       = 1'b0;
        req_i        = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_result_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", PW'(busy_o), PW'(0));
        check("rst_outstanding", PW'(outstanding_o), PW'(0));
        check("rst_err", PW'(err_o), PW'(0));
        check("rst_gnt", PW'(gnt_o), PW'(0));
        check("rst_rvalid", PW'(rvalid_o), PW'(0));
        rst_ni = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            req_i        = vecs[i].req;
            apu_gnt_i    = vecs[i].gnt;
            apu_rvalid_i = vecs[i].rv;
            apu_result_i = (vecs[i].res != '0) ? vecs[i].res : {5'($urandom), 32'($urandom)};
            #4;
            check($sformatf("v%0d_gnt", i), PW'(gnt_o), PW'(vecs[i].egnt));
            check($sformatf("v%0d_rvalid", i), PW'(rvalid_o), PW'(vecs[i].erv));
            check($sformatf("v%0d_apu_req", i), PW'(apu_req_o), PW'(vecs[i].eareq));
            check($sformatf("v%0d_outstanding", i), PW'(outstanding_o), PW'(vecs[i].eout));
            check($sformatf("v%0d_busy", i), PW'(busy_o), PW'(vecs[i].eout != 0));
            check($sformatf("v%0d_err", i), PW'(err_o), PW'(vecs[i].eerr));
            check($sformatf("v%0d_result", i), PW'(result_o), PW'(apu_result_i));
            if (vecs[i].eareq) begin
                check($sformatf("v%0d_payload", i), apu_payload_o, pay[vecs[i].psel]);
            end
            sb_check();
            if ((vecs[i].req & vecs[i].egnt) != '0) begin
                exp_q.push_back(vecs[i].egnt[1] ? 1 : 0);
            end
        end

        // Reset with two operations outstanding, then a stray response and a fresh arbitration.
        @(posedge clk);
        #1;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        rst_ni       = 1'b0;
        #1;
        check("mid_rst_busy", PW'(busy_o), PW'(0));
        check("mid_rst_outstanding", PW'(outstanding_o), PW'(0));
        check("mid_rst_err", PW'(err_o), PW'(0));
        check("mid_rst_apu_req", PW'(apu_req_o), PW'(1));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_ni       = 1'b1;
        req_i        = 2'b00;
        apu_rvalid_i = 1'b1;
        #4;
        check("post_rst_stray_rvalid", PW'(rvalid_o), PW'(0));
        @(posedge clk);
        #1;
        apu_rvalid_i = 1'b0;
        req_i        = 2'b11;
        apu_gnt_i    = 1'b1;
        #4;
        check("post_rst_err", PW'(err_o), PW'(1));
        check("post_rst_gnt", PW'(gnt_o), PW'(2'b01));
        check("post_rst_outstanding", PW'(outstanding_o), PW'(0));
        exp_q.push_back(0);
        @(posedge clk);
        #1;
        req_i        = 2'b00;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b1;
        #4;
        check("post_rst_rvalid", PW'(rvalid_o), PW'(2'b01));
        sb_check();
        @(posedge clk);
        #1;
        apu_rvalid_i = 1'b0;
        #4;
        check("final_outstanding", PW'(outstanding_o), PW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
